hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Producer of the RAW hazard bus consumed by the decode stage. Tracks the destination
//  register of every in-flight instruction in the EX/MEM/WB slots and compares it with
//  the decode-stage sources. Drives the forwarding selects {RAW_hazards, RAW_mem_wb_hazards},
//  we_valid, and the load-use stall/bubble controls.
// PARAMETERS
//  LOAD_IN_WB  1  1: load data exists only at WB output, so a matching load in EX/MEM stalls
//                 0: a load in MEM forwards like ALU data (memory_data)
// PORTS
//  clk                 in   1  clock, all state on posedge
//  rst                 in   1  asynchronous, active-low reset
//  dec_valid           in   1  decode holds a real instruction
//  dec_rs1             in   5  decode rs1 (already forced to 0 for LUI)
//  dec_rs2             in   5  decode rs2
//  dec_rs2_used        in   1  rs2 is a true source (R, S, B types)
//  dec_rd              in   5  decode rd
//  dec_rf_wb           in   1  decode instruction writes the regfile
//  dec_is_load         in   1  decode instruction is a load (wb_src[1])
//  flush               in   1  taken branch/jump resolved in EX; kill the decode instruction
//  raw_hazards         out  4  {rs1_ex, rs2_ex, rs1_mem, rs2_mem}
//  raw_mem_wb_hazards  out  2  {rs1_load_wb, rs2_load_wb}
//  we_valid            out  1  WB slot valid (qualifies we_wb in decode)
//  stall               out  1  hold PC and IF/DEC register this cycle
//  bubble              out  1  EX slot loads a NOP next edge
// BEHAVIOUR
//  - State: three slots EX, MEM, WB; each holds {v, rd[4:0], wb, ld}.
//  - Reset (rst=0, async): all slot v=0. With empty slots every output is 0 regardless of the
//    dec_* inputs; stall and bubble are 0.
//  - Match: m_S(r) = S.v & S.wb & (S.rd != 0) & (r == S.rd) & dec_valid. rs2 terms are
//    additionally ANDed with dec_rs2_used.
//  - rs1_ex  = m_EX(rs1) & ~EX.ld;   rs1_mem = m_MEM(rs1) & ~(MEM.ld & LOAD_IN_WB).
//    rs2 terms are identical with rs2.
//  - rs1_load_wb = m_WB(rs1) & WB.ld & ~m_EX(rs1) & ~m_MEM(rs1). This selects the regfile
//    path, which decode bypasses from wb_data. rs2 is identical.
//  - ld_hz = (m_EX(rs1)|m_EX(rs2)) & EX.ld, OR'd with (m_MEM(rs1)|m_MEM(rs2)) & MEM.ld when
//    LOAD_IN_WB=1.
//  - stall = ld_hz & ~flush;  bubble = ld_hz | flush.  Flush has priority over stall.
//  - Back-to-back load-use stalls 2 cycles (LOAD_IN_WB=1) or 1 cycle (LOAD_IN_WB=0).
//  - Youngest producer wins: the EX match masks MEM and WB matches of the same source.
//  - All hazard, stall and bubble outputs are combinational from the slots and dec_* inputs.
//    we_valid = WB.v. No output has a combinational path from flush except stall and bubble.
//  - Per posedge, with the slots advancing every cycle (no back-pressure):
//      WB  <= MEM
//      MEM <= EX
//      EX  <= bubble ? 0 : {dec_valid, dec_rd, dec_rf_wb, dec_is_load}
//  - Writes to x0 never raise a hazard or stall.
//  - Reset mid-stall clears all slots. stall drops in the same cycle rst falls.
// CONFIGURATION
//  HAZARD_STATS_EN defined:
//   - adds out ports stall_cnt[31:0] and flush_cnt[31:0].
//   - stall_cnt increments on every cycle with stall=1.
//   - flush_cnt increments on every cycle with flush=1.
//   - Both counters saturate at all-ones and reset to 0.
//  HAZARD_STATS_EN undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
//  1 add x5,x1,x2 then add x6,x5,x3 -> cycle 2: raw_hazards=4'b1000, stall=0, bubble=0.
//  2 add x5 ; nop ; sub x7,x1,x5 (rs2_used=1) -> raw_hazards=4'b0001; with rs2_used=0
//    -> raw_hazards=4'b0000.
//  3 lw x5 ; add x7,x5,x5 (LOAD_IN_WB=1) -> stall=1 and bubble=1 for 2 cycles, then
//    raw_mem_wb_hazards=2'b11 and raw_hazards=0.
//  4 addi x0,x1,1 ; add x2,x0,x0 -> every hazard output is 0.
//  5 lw x5 followed by a dependent add, with flush=1 in the first stall cycle -> stall=0,
//    bubble=1, and EX.v=0 next cycle.
//  6 rst low during a load-use stall -> stall=0 and we_valid=0 immediately. After release
//    with dec_valid=0 every output stays 0. Under HAZARD_STATS_EN, stall_cnt reads 0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode <-> hazard scoreboard bus: decode-stage operands in, forwarding selects and
// load-use stall/bubble controls out.
interface hazard_scoreboard_if;
  // dec_valid qualifies every dec_* field in the same cycle. There is no ready: the
  // scoreboard never back-pressures, and stall is the only hold it asks for.
  logic       dec_valid;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       dec_rs2_used;
  logic [4:0] dec_rd;
  logic       dec_rf_wb;
  logic       dec_is_load;
  logic       flush;
  logic [3:0] raw_hazards;
  logic [1:0] raw_mem_wb_hazards;
  logic       we_valid;
  logic       stall;
  logic       bubble;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs2_used, dec_rd, dec_rf_wb, dec_is_load, flush,
    input  raw_hazards, raw_mem_wb_hazards, we_valid, stall, bubble
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs2_used, dec_rd, dec_rf_wb, dec_is_load, flush,
    output raw_hazards, raw_mem_wb_hazards, we_valid, stall, bubble
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: tracks rd of the EX/MEM/WB slots and drives forwarding selects
// and load-use stall/bubble. Optional HAZARD_STATS_EN adds stall/flush counters.
module hazard_scoreboard #(
  parameter bit LOAD_IN_WB = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wb;
    logic       ld;
  } slot_t;

  slot_t ex_s, mem_s, wb_s;

  logic m_ex1, m_ex2, m_mem1, m_mem2, m_wb1, m_wb2;
  logic ld_hz, stall, bubble;

  function automatic logic slot_match(input slot_t s, input logic [4:0] r);
    return s.v & s.wb & (s.rd != 5'd0) & (r == s.rd);
  endfunction

  // Younger producers mask older ones, so MEM/WB matches are cleared by an EX match.
  always_comb begin
    m_ex1  = slot_match(ex_s, hz.dec_rs1) & hz.dec_valid;
    m_ex2  = slot_match(ex_s, hz.dec_rs2) & hz.dec_valid & hz.dec_rs2_used;
    m_mem1 = slot_match(mem_s, hz.dec_rs1) & hz.dec_valid & ~m_ex1;
    m_mem2 = slot_match(mem_s, hz.dec_rs2) & hz.dec_valid & hz.dec_rs2_used & ~m_ex2;
    m_wb1  = slot_match(wb_s, hz.dec_rs1) & hz.dec_valid & ~m_ex1 & ~m_mem1;
    m_wb2  = slot_match(wb_s, hz.dec_rs2) & hz.dec_valid & hz.dec_rs2_used & ~m_ex2 & ~m_mem2;
  end

  always_comb begin
    ld_hz  = ((m_ex1 | m_ex2) & ex_s.ld) |
             ((m_mem1 | m_mem2) & mem_s.ld & LOAD_IN_WB);
    stall  = ld_hz & ~hz.flush;
    bubble = ld_hz | hz.flush;
  end

  always_comb begin
    hz.raw_hazards = {m_ex1 & ~ex_s.ld,
                      m_ex2 & ~ex_s.ld,
                      m_mem1 & ~(mem_s.ld & LOAD_IN_WB),
                      m_mem2 & ~(mem_s.ld & LOAD_IN_WB)};
    hz.raw_mem_wb_hazards = {m_wb1 & wb_s.ld, m_wb2 & wb_s.ld};
    hz.we_valid = wb_s.v;
    hz.stall    = stall;
    hz.bubble   = bubble;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_s  <= '0;
      mem_s <= '0;
      wb_s  <= '0;
    end else begin
      wb_s  <= mem_s;
      mem_s <= ex_s;
      ex_s  <= bubble ? slot_t'('0)
                      : slot_t'({hz.dec_valid, hz.dec_rd, hz.dec_rf_wb, hz.dec_is_load});
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (hz.flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (default LOAD_IN_WB=1); inputs driven on the
// falling edge, combinational outputs checked before the next rising edge.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if bus();
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_scoreboard dut (
    .clk(clk),
    .rst(rst),
    .hz(bus)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  int total = 0;
  int bad = 0;
  logic [8:0] exp_q[$];

  // {raw_hazards, raw_mem_wb_hazards, we_valid, stall, bubble}
  function automatic logic [8:0] outs();
    return {bus.raw_hazards, bus.raw_mem_wb_hazards, bus.we_valid, bus.stall, bus.bubble};
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic rs2u, input logic [4:0] rd, input logic wbf,
                       input logic ld, input logic fl);
    bus.dec_valid    = v;
    bus.dec_rs1      = rs1;
    bus.dec_rs2      = rs2;
    bus.dec_rs2_used = rs2u;
    bus.dec_rd       = rd;
    bus.dec_rf_wb    = wbf;
    bus.dec_is_load  = ld;
    bus.flush        = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic flush_pipe();
    idle();
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    total++;
    if (outs() !== 9'b0) begin
      bad++; $display("FAIL reset_outs got=%b exp=%b", outs(), 9'b0);
    end
    step();
    idle();
    rst = 1'b1;
  endtask

  task automatic test_ex_forward();
    flush_pipe();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    total++;
    if (outs() !== 9'b0) begin
      bad++; $display("FAIL ex_fwd_first got=%b exp=%b", outs(), 9'b0);
    end
    step();
    drive(1'b1, 5'd5, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    total++;
    if (outs() !== 9'b1000_00_0_00) begin
      bad++; $display("FAIL ex_fwd_rs1 got=%b exp=%b", outs(), 9'b1000_00_0_00);
    end
  endtask

  task automatic test_mem_forward();
    flush_pipe();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    step();
    drive(1'b1, 5'd1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    total++;
    if (outs() !== 9'b0001_00_0_00) begin
      bad++; $display("FAIL mem_fwd_rs2 got=%b exp=%b", outs(), 9'b0001_00_0_00);
    end
    drive(1'b1, 5'd1, 5'd5, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    total++;
    if (outs() !== 9'b0) begin
      bad++; $display("FAIL mem_fwd_rs2_unused got=%b exp=%b", outs(), 9'b0);
    end
  endtask

  task automatic test_load_use();
    logic [8:0] exp;
    flush_pipe();
    drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(9'b0000_00_0_11);
    exp_q.push_back(9'b0000_00_0_11);
    exp_q.push_back(9'b0000_11_1_00);
    for (int i = 0; i < 3; i++) begin
      exp = exp_q.pop_front();
      total++;
      if (outs() !== exp) begin
        bad++; $display("FAIL load_use_cyc%0d got=%b exp=%b", i, outs(), exp);
      end
      step();
      #1;
    end
  endtask

  task automatic test_x0();
    flush_pipe();
    drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
    total++;
    if (outs() !== 9'b0) begin
      bad++; $display("FAIL x0_ex got=%b exp=%b", outs(), 9'b0);
    end
    step();
    step();
    #1;
    total++;
    if (outs() !== 9'b0000_00_1_00) begin
      bad++; $display("FAIL x0_wb got=%b exp=%b", outs(), 9'b0000_00_1_00);
    end
  endtask

  task automatic test_youngest_wins();
    flush_pipe();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    total++;
    if (outs() !== 9'b1100_00_0_00) begin
      bad++; $display("FAIL youngest_wins got=%b exp=%b", outs(), 9'b1100_00_0_00);
    end
  endtask

  task automatic test_flush();
    flush_pipe();
    drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    total++;
    if (outs() !== 9'b0000_00_0_01) begin
      bad++; $display("FAIL flush_prio got=%b exp=%b", outs(), 9'b0000_00_0_01);
    end
    step();
    drive(1'b1, 5'd7, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    total++;
    if (outs() !== 9'b0) begin
      bad++; $display("FAIL flush_ex_empty got=%b exp=%b", outs(), 9'b0);
    end
  endtask

  task automatic test_reset_mid_stall();
    flush_pipe();
    drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    total++;
    if (outs() !== 9'b0000_00_0_11) begin
      bad++; $display("FAIL rst_pre_stall got=%b exp=%b", outs(), 9'b0000_00_0_11);
    end
    #1 rst = 1'b0;
    #1;
    total++;
    if (outs() !== 9'b0) begin
      bad++; $display("FAIL rst_mid_stall got=%b exp=%b", outs(), 9'b0);
    end
    step();
    idle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      total++;
      if (outs() !== 9'b0) begin
        bad++; $display("FAIL rst_release_cyc%0d got=%b exp=%b", i, outs(), 9'b0);
      end
    end
`ifdef HAZARD_STATS_EN
    total++;
    if (stall_cnt !== 32'd0) begin
      bad++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt);
    end
`endif
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    step();
    step();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    total++;
    if (stall_cnt !== 32'd2) begin
      bad++; $display("FAIL stats_stall got=%0d exp=2", stall_cnt);
    end
    total++;
    if (flush_cnt !== 32'd1) begin
      bad++; $display("FAIL stats_flush got=%0d exp=1", flush_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_x0();
    test_youngest_wins();
    test_flush();
    test_reset_mid_stall();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
